// File: rtl/rld_if.sv
// rld_if: port-A bundle of the shared dual-port SRAM.
//   clk       SRAM clock (driven by the master from its own clock)
//   addr      16-bit byte address
//   we        1 = write, 0 = read
//   data_in   write data toward the SRAM
//   data_out  read data from the SRAM, valid the cycle after addr
// master modport: the block driving the SRAM; slave modport: the SRAM.
interface rld_if;
   logic        clk;
   logic [15:0] addr;
   logic        we;
   logic [31:0] data_in;
   logic [31:0] data_out;

   modport master (output clk, addr, we, data_in, input data_out);
   modport slave  (input clk, addr, we, data_in, output data_out);
endinterface

// File: rtl/rld.sv
// rld: run-length decoder. Reads (count, byte) pairs from the shared SRAM
// starting at rle_addr, expands each into count copies of byte and writes the
// result back through port A, packed little-endian four bytes per word at
// message_addr. Start/done handshake matches the RLE compressor.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   start                begin decode (sampled in IDLE only)
//   rle_addr, rle_size   compressed frame byte address / length in bytes
//   message_addr         decoded output byte address
//   message_size         decoded byte count, valid while done=1
//   done                 decode complete, held until the next accepted start
//   error                (only with RLD_ERR_EN) zero count or odd rle_size seen
//   port_A               SRAM port A (rld_if master)
//
// Build option: define RLD_ERR_EN to add the error output.
module rld (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [31:0] rle_addr,
   input  logic [31:0] rle_size,
   input  logic [31:0] message_addr,
   output logic [31:0] message_size,
   output logic        done,
`ifdef RLD_ERR_EN
   output logic        error,
`endif
   rld_if.master       port_A
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_CAP, S_EXPAND, S_WR, S_FLUSH, S_DONE
   } state_t;

   state_t      state_q;
   logic [31:0] rd_ptr_q, wr_ptr_q;
   logic [31:0] word_q;      // compressed word being expanded
   logic [31:0] buf_q;       // output pack buffer
   logic [31:0] data_q;      // registered write data
   logic [31:0] msize_q;
   logic [30:0] pairs_q;     // pairs still to decode, including the current one
   logic [7:0]  cnt_q;       // copies left of the current pair
   logic [1:0]  bidx_q;      // bytes already in the pack buffer
   logic        pair_sel_q;  // 0 = pair0 of word_q, 1 = pair1
   logic        word_done_q; // word_q fully consumed (remembered across WR)
   logic        we_q;
   logic        done_q;
`ifdef RLD_ERR_EN
   logic        err_q;
`endif

   // EXPAND-cycle next values
   logic        emit_d, pair_end_d, last_in_word_d, word_end_d, full_d;
   logic [7:0]  cur_byte_d;
   logic [30:0] pairs_d;
   logic [31:0] buf_d;
   logic [1:0]  bidx_d;

   always_comb begin
      cur_byte_d     = pair_sel_q ? word_q[31:24] : word_q[15:8];
      emit_d         = (cnt_q != 8'd0);
      // a zero-count pair ends immediately without emitting
      pair_end_d     = !emit_d || (cnt_q == 8'd1);
      // pair0 is the last valid pair of the word when only one pair remains
      last_in_word_d = pair_sel_q || (pairs_q == 31'd1);
      word_end_d     = pair_end_d && last_in_word_d;
      pairs_d        = pair_end_d ? pairs_q - 31'd1 : pairs_q;
      buf_d          = buf_q;
      if (emit_d) buf_d[{bidx_q, 3'b000} +: 8] = cur_byte_d;
      bidx_d         = bidx_q + {1'b0, emit_d};
      full_d         = emit_d && (bidx_q == 2'd3);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         word_q      <= '0;
         buf_q       <= '0;
         data_q      <= '0;
         msize_q     <= '0;
         pairs_q     <= '0;
         cnt_q       <= '0;
         bidx_q      <= '0;
         pair_sel_q  <= 1'b0;
         word_done_q <= 1'b0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
`ifdef RLD_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rd_ptr_q <= rle_addr;
                  wr_ptr_q <= message_addr;
                  pairs_q  <= rle_size[31:1];
                  msize_q  <= '0;
                  buf_q    <= '0;
                  bidx_q   <= '0;
                  done_q   <= 1'b0;
`ifdef RLD_ERR_EN
                  err_q    <= rle_size[0];
`endif
                  state_q  <= (rle_size < 32'd2) ? S_DONE : S_RD;
               end
            end
            S_RD: state_q <= S_CAP;
            S_CAP: begin
               word_q      <= port_A.data_out;
               cnt_q       <= port_A.data_out[7:0];
               pair_sel_q  <= 1'b0;
               word_done_q <= 1'b0;
               rd_ptr_q    <= rd_ptr_q + 32'd4;
               state_q     <= S_EXPAND;
            end
            S_EXPAND: begin
               buf_q       <= buf_d;
               bidx_q      <= bidx_d;
               pairs_q     <= pairs_d;
               word_done_q <= word_end_d;
               if (emit_d) begin
                  msize_q <= msize_q + 32'd1;
                  cnt_q   <= cnt_q - 8'd1;
               end
`ifdef RLD_ERR_EN
               else err_q <= 1'b1;
`endif
               if (pair_end_d && !last_in_word_d) begin
                  pair_sel_q <= 1'b1;
                  cnt_q      <= word_q[23:16];
               end
               if (full_d) begin
                  state_q <= S_WR;
                  we_q    <= 1'b1;
                  data_q  <= buf_d;
               end else if (word_end_d) begin
                  if (pairs_d != 31'd0) state_q <= S_RD;
                  else if (bidx_d != 2'd0) begin
                     state_q <= S_FLUSH;
                     we_q    <= 1'b1;
                     data_q  <= buf_d;
                  end else state_q <= S_DONE;
               end
            end
            S_WR: begin
               we_q     <= 1'b0;
               wr_ptr_q <= wr_ptr_q + 32'd4;
               buf_q    <= '0;
               if (!word_done_q)          state_q <= S_EXPAND;
               else if (pairs_q != 31'd0) state_q <= S_RD;
               else                       state_q <= S_DONE;
            end
            S_FLUSH: begin
               we_q     <= 1'b0;
               wr_ptr_q <= wr_ptr_q + 32'd4;
               buf_q    <= '0;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign port_A.clk     = clk;
   assign port_A.we      = we_q;
   assign port_A.addr    = we_q ? wr_ptr_q[15:0] : rd_ptr_q[15:0];
   assign port_A.data_in = data_q;
   assign message_size   = msize_q;
   assign done           = done_q;
`ifdef RLD_ERR_EN
   assign error          = err_q;
`endif

endmodule

// File: tb/tb_rld.sv
// tb_rld: self-checking bench for rld. A read-only SRAM image feeds the
// decoder, a monitor records every port-A write, and a byte-level model
// (pairs -> byte list -> little-endian words) supplies the expected results.
module tb_rld;
   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] rle_addr = '0, rle_size = '0, message_addr = '0;
   logic [31:0] message_size;
   logic        done;
`ifdef RLD_ERR_EN
   logic        error;
`endif

   rld_if port_A ();

   rld dut (
      .clk(clk), .nreset(nreset), .start(start),
      .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
      .message_size(message_size), .done(done),
`ifdef RLD_ERR_EN
      .error(error),
`endif
      .port_A(port_A)
   );

   always #5 clk = ~clk;

   // SRAM read side: compressed image, one-cycle read latency
   logic [31:0] rom [0:16383];
   always @(posedge port_A.clk) port_A.data_out <= rom[port_A.addr[15:2]];

   // write monitor
   logic [15:0] wa [0:8191];
   logic [31:0] wd [0:8191];
   int          wcnt = 0;
   always @(negedge clk)
      if (port_A.we === 1'b1) begin
         wa[wcnt % 8192] <= port_A.addr;
         wd[wcnt % 8192] <= port_A.data_in;
         wcnt            <= wcnt + 1;
      end

   int n_chk = 0, n_fail = 0;
   logic [31:0] fw [0:7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Load frame, start, optionally poke start while busy, wait for done and
   // compare every write plus message_size (and error) with the model.
   task automatic run_frame(input string tag, input logic [31:0] ra, input logic [31:0] rs,
                            input logic [31:0] ma, input int nw, input bit poke);
      logic [7:0]  exp_b[$];
      logic [31:0] w, ew;
      logic [7:0]  c, b;
      bit          err;
      int          base, nexp, cyc, np;
      for (int i = 0; i < nw; i++) rom[(ra[15:2] + 14'(i))] = fw[i];
      exp_b.delete();
      np  = int'(rs >> 1);
      err = rs[0];
      for (int p = 0; p < np; p++) begin
         w = fw[p / 2];
         c = (p % 2 == 1) ? w[23:16] : w[7:0];
         b = (p % 2 == 1) ? w[31:24] : w[15:8];
         if (c == 8'd0) err = 1'b1;
         for (int k = 0; k < int'(c); k++) exp_b.push_back(b);
      end
      nexp = (exp_b.size() + 3) / 4;

      @(negedge clk);
      rle_addr = ra; rle_size = rs; message_addr = ma; start = 1'b1;
      base = wcnt;
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         rle_size = 32'd0; rle_addr = 32'h0000_0040; start = 1'b1;
         @(negedge clk);
         start = 1'b0; rle_size = rs; rle_addr = ra;
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) chk({tag, "_timeout"}, {31'b0, done}, 32'd1);
      chk({tag, "_msize"}, message_size, 32'(exp_b.size()));
      chk({tag, "_nwr"}, 32'(wcnt - base), 32'(nexp));
      for (int j = 0; j < nexp && j < wcnt - base; j++) begin
         ew = '0;
         for (int k = 0; k < 4; k++)
            if (4 * j + k < exp_b.size()) ew[8 * k +: 8] = exp_b[4 * j + k];
         chk({tag, "_waddr"}, {16'h0, wa[(base + j) % 8192]}, {16'h0, ma[15:0] + 16'(4 * j)});
         chk({tag, "_wdata"}, wd[(base + j) % 8192], ew);
      end
`ifdef RLD_ERR_EN
      chk({tag, "_error"}, {31'b0, error}, {31'b0, err});
`endif
   endtask

   initial begin
      int base, nw;
      logic [31:0] rs;
      for (int i = 0; i < 16384; i++) rom[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_msize", message_size, 32'd0);
      chk("rst_we", {31'b0, port_A.we}, 32'd0);
      chk("rst_addr", {16'h0, port_A.addr}, 32'd0);
      chk("rst_din", port_A.data_in, 32'd0);
`ifdef RLD_ERR_EN
      chk("rst_error", {31'b0, error}, 32'd0);
`endif
      nreset = 1'b1;

      // directed cases
      fw[0] = 32'h42024103;
      run_frame("basic", 32'h0000_1000, 32'd4, 32'h0000_8000, 1, 1'b0);
      fw[0] = 32'h0000FFFF;
      run_frame("cnt255", 32'h0000_1100, 32'd2, 32'h0001_9000, 1, 1'b1);
      fw[0] = 32'h62016101; fw[1] = 32'h00006302;
      run_frame("exact4", 32'h0000_1200, 32'd6, 32'h0000_A000, 2, 1'b0);
      fw[0] = 32'h42004101;
      run_frame("zcnt", 32'h0000_1300, 32'd4, 32'h0000_A100, 1, 1'b1);
      fw[0] = 32'h42024103; fw[1] = 32'h000000AA;
      run_frame("odd", 32'h0000_1400, 32'd5, 32'h0000_A200, 2, 1'b0);

      // rle_size = 0: done exactly two cycles after start, no writes
      @(negedge clk);
      rle_size = 32'd0; message_addr = 32'h0000_B000; start = 1'b1;
      base = wcnt;
      @(negedge clk);
      start = 1'b0;
      chk("sz0_done_c1", {31'b0, done}, 32'd0);
      @(negedge clk);
      chk("sz0_done_c2", {31'b0, done}, 32'd1);
      chk("sz0_msize", message_size, 32'd0);
      chk("sz0_nwr", 32'(wcnt - base), 32'd0);

      // reset during EXPAND, then the same frame again
      fw[0] = 32'h42024103;
      rom[14'h0500] = fw[0];
      @(negedge clk);
      rle_addr = 32'h0000_1400; rle_size = 32'd4; message_addr = 32'h0000_C000; start = 1'b1;
      base = wcnt;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      nreset = 1'b0;
      #1;
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_msize", message_size, 32'd0);
      chk("mid_rst_we", {31'b0, port_A.we}, 32'd0);
      chk("mid_rst_addr", {16'h0, port_A.addr}, 32'd0);
      chk("mid_rst_din", port_A.data_in, 32'd0);
      repeat (4) @(negedge clk);
      chk("mid_rst_nwr", 32'(wcnt - base), 32'd0);
      nreset = 1'b1;
      run_frame("after_rst", 32'h0000_1400, 32'd4, 32'h0000_C000, 1, 1'b0);

      // randomized frames
      for (int it = 0; it < 25; it++) begin
         nw = int'($urandom_range(1, 6));
         for (int i = 0; i < nw; i++) begin
            fw[i] = $urandom;
            fw[i][7:0]   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            fw[i][23:16] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
         end
         rs = 32'($urandom_range(0, 4 * nw));
         run_frame("rand", {16'($urandom), 16'h2000 + 16'(it * 32)},
                   rs, {16'($urandom), 16'h8000 + 16'(it * 512)}, nw,
                   (it % 2 == 1) && (rs >= 32'd2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rld.md
# rld

Run-length decoder: the inverse of the team's RLE compressor. On `start` it reads a compressed frame of (count, byte) pairs from the shared dual-port SRAM, expands each pair into `count` copies of `byte`, and writes the expanded plaintext back to the same SRAM through port A, packed four bytes per word. It sits beside the compressor on the same SRAM port and uses the same start/done handshake.

## Interface
- No parameters.
- `clk`  in  1  system clock; also drives `port_A_clk`.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin decode; sampled only in IDLE.
- `rle_addr`  in  32  byte address of the compressed frame; word aligned.
- `rle_size`  in  32  compressed length in bytes.
- `message_addr`  in  32  byte address for the decoded output; word aligned.
- `message_size`  out  32  decoded bytes written; valid while `done`=1.
- `done`  out  1  decode complete; held until the next accepted `start`.
- `port_A_clk`  out  1  equals `clk`.
- `port_A_addr`  out  16  SRAM byte address, low 16 bits of the internal pointer.
- `port_A_we`  out  1  1 = write, 0 = read.
- `port_A_data_in`  out  32  write data to the SRAM.
- `port_A_data_out`  in  32  read data from the SRAM; valid the cycle after the address is driven.
- `error`  out  1  present only with `RLD_ERR_EN`; see Configuration.

## Operation
- Compressed word layout: `[7:0]` count0, `[15:8]` byte0, `[23:16]` count1, `[31:24]` byte1. Pair0 is processed before pair1.
- Pairs to decode = `rle_size>>1`. If `rle_size[1]`=1, only pair0 of the last word is valid. An odd trailing byte is ignored.
- Output packing is little-endian: output byte k goes to bits `[8*(k%4)+7 : 8*(k%4)]` of word `message_addr + 4*(k/4)`.
- A count of 0 emits no bytes. It is skipped silently unless `RLD_ERR_EN` is defined.
- States and transitions:
  - IDLE: on `start`, latch the addresses and size, clear `message_size`, the pack buffer and `done`. Go to RD, or to DONE if `rle_size<2`.
  - RD: drive the read pointer with `we`=0, then go to CAP.
  - CAP: latch `port_A_data_out`, advance the read pointer by 4, go to EXPAND.
  - EXPAND: each cycle place the current byte into the pack buffer, decrement the pair count and increment `message_size`.
    - When the 4th buffer byte is placed, go to WR.
    - When the word's valid pairs are exhausted: go to RD if pairs remain; otherwise go to FLUSH if the buffer is partially filled, else DONE.
  - WR: `we`=1, address = write pointer, data = buffer. Advance the write pointer by 4, clear the buffer, then resume EXPAND, or go to RD/DONE by the same exhaustion rule.
  - FLUSH: one write cycle of the partial buffer with its unused upper bytes 0, then DONE.
  - DONE: set `done`=1 and go to IDLE.
- `start` is ignored outside IDLE.
- Widths: counts are 8-bit (1..255); `message_size` and both pointers are 32-bit and wrap modulo 2^32. Only the low 16 bits of the active pointer reach `port_A_addr`.
- `port_A_addr` shows the write pointer when `we`=1 and the read pointer otherwise.

## Timing
- Reset values: `done`=0, `message_size`=0, `port_A_we`=0, `port_A_addr`=0, `port_A_data_in`=0, `error`=0. State goes to IDLE.
- Reset mid-operation aborts at once. No further writes occur, and the next `start` decodes normally.
- Read latency: 2 cycles per compressed word (RD, CAP).
- Throughput: 1 output byte per EXPAND cycle, plus 1 WR cycle per 4 output bytes.
- Skipping a zero-count pair costs 1 cycle.
- `done` rises 1 cycle after the last write. It stays high through IDLE and drops on the cycle after an accepted `start`.
- `rle_size`=0: `done` is high 2 cycles after `start`, with no write and no read.

## Configuration
- `RLD_ERR_EN` defined: adds the `error` output.
  - `error` is set when a zero-count pair is seen, or when `rle_size` is odd.
  - Decoding continues and the pair is skipped; `error` is cleared on an accepted `start`.
- `RLD_ERR_EN` undefined: no `error` port, and those conditions are handled silently as described in Operation.

## Test plan
- Word 0x42024103 at `rle_addr`, `rle_size`=4 → 0x42414141 written at `message_addr` and 0x00000042 at +4; `message_size`=5; `done`=1.
- `rle_size`=0 → `port_A_we` never asserted, `message_size`=0, `done`=1 two cycles after `start`.
- Word 0x0000FFFF (count 255 of 0xFF), `rle_size`=2 → 63 words of 0xFFFFFFFF, then 0x00FFFFFF; `message_size`=255; upper pair ignored.
- `rle_size`=6 across words 0x62016101 and 0x00006302 → one word 0x63636261 written; `message_size`=4; no FLUSH write.
- Assert `nreset` during EXPAND → all outputs at reset values, no further `we`; a second `start` reproduces the first scenario exactly.
- Word 0x42004101, `rle_size`=4 → 0x00000041 written, `message_size`=1; `error`=1 only when built with `RLD_ERR_EN`. `start` pulses while busy cause no change.
